mash_div_ctrl: RTL and testbench

MASH_DIV_CTRL -- requirements
Module: mash_div_ctrl

---
 rtl/div_pkg.sv | 26 ++
 rtl/mod_calc.sv | 38 +++
 rtl/mash_div_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_mash_div_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Package  : div_pkg
// Purpose  : Shared widths, modulus limits and FSM state type for the
//            MASH fractional-N divider controller.
// Revision : 1.0 - initial release
// ============================================================================
package div_pkg;

    localparam int N_W    = 8;   // integer part N
    localparam int F_W    = 16;  // fractional word F
    localparam int C_W    = 4;   // sigma-delta correction (signed)
    localparam int MRAW_W = 10;  // signed sum N + c before clamping
    localparam int PCNT_W = 16;  // optional pulse counter

    localparam logic [N_W-1:0] MOD_MIN = 8'd2;
    localparam logic [N_W-1:0] MOD_MAX = 8'd255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_e;

endpackage : div_pkg
`default_nettype wire

// File: rtl/mod_calc.sv
`default_nettype none
// ============================================================================
// Module   : mod_calc
// Purpose  : Combinational modulus computation: M = clamp(N + c) where c is
//            the signed sigma-delta output, limited to [MOD_MIN, MOD_MAX].
// Revision : 1.0 - initial release
// ============================================================================
module mod_calc
    import div_pkg::*;
(
    input  logic [N_W-1:0] i_n_int,
    input  logic [C_W-1:0] i_ddsm_c,
    output logic [N_W-1:0] o_modulus,
    output logic           o_clamped
);

    localparam logic signed [MRAW_W-1:0] C_LO = MRAW_W'(MOD_MIN);
    localparam logic signed [MRAW_W-1:0] C_HI = MRAW_W'(MOD_MAX);

    logic signed [MRAW_W-1:0] w_mraw;

    // Widen both operands to the signed sum width, then saturate
    always_comb begin
        w_mraw    = $signed({{(MRAW_W-N_W){1'b0}}, i_n_int})
                  + $signed({{(MRAW_W-C_W){i_ddsm_c[C_W-1]}}, i_ddsm_c});
        o_modulus = w_mraw[N_W-1:0];
        o_clamped = 1'b0;
        if (w_mraw < C_LO) begin
            o_modulus = MOD_MIN;
            o_clamped = 1'b1;
        end else if (w_mraw > C_HI) begin
            o_modulus = MOD_MAX;
            o_clamped = 1'b1;
        end
    end

endmodule : mod_calc
`default_nettype wire

// File: rtl/mash_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mash_div_ctrl
// Purpose  : Fractional-N divider sequencer. Runs a down-counter whose period
//            is N + sigma-delta correction, double-buffers the divide ratio
//            through a shadow register and applies it on a period boundary.
// Options  : define DIV_PULSE_CNT_EN to add the 16-bit pulse_cnt output.
// Revision : 1.0 - initial release
// ============================================================================
module mash_div_ctrl
    import div_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [N_W-1:0]    cfg_int,
    input  logic [F_W-1:0]    cfg_frac,
    input  logic [C_W-1:0]    ddsm_c,
    output logic [F_W-1:0]    frac_word,
    output logic              div_out,
    output logic [N_W-1:0]    modulus,
    output logic              clamp_flag
`ifdef DIV_PULSE_CNT_EN
    ,
    output logic [PCNT_W-1:0] pulse_cnt
`endif
);

    localparam logic [N_W-1:0] C_ONE = 8'd1;

    state_e         state_q, state_d;
    logic [N_W-1:0] cnt_q, cnt_d;
    logic [N_W-1:0] mod_q, mod_d;
    logic [N_W-1:0] act_int_q, act_int_d;
    logic [F_W-1:0] act_frac_q, act_frac_d;
    logic [N_W-1:0] shd_int_q, shd_int_d;
    logic [F_W-1:0] shd_frac_q, shd_frac_d;
    logic           pend_q, pend_d;
    logic           clamp_q, clamp_d;

    logic           w_active;
    logic           w_div;
    logic           w_hs;
    logic           w_start;
    logic           w_load;
    logic           w_apply;
    logic [N_W-1:0] w_n_eff;
    logic [N_W-1:0] w_mod;
    logic           w_clamped;

    // A pending word is applied either while parked in IDLE or at the
    // period boundary in PEND; the reload then already uses the new N.
    assign w_hs    = cfg_valid & ~pend_q;
    assign w_start = (state_q == ST_IDLE) & enable;
    assign w_load  = w_start | w_div;
    assign w_apply = pend_q & ((state_q == ST_IDLE) | ((state_q == ST_PEND) & w_div));
    assign w_n_eff = w_apply ? shd_int_q : act_int_q;

    mod_calc u_mod_calc (
        .i_n_int   (w_n_eff),
        .i_ddsm_c  (ddsm_c),
        .o_modulus (w_mod),
        .o_clamped (w_clamped)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; dropping enable always parks the divider in IDLE
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = w_hs ? ST_PEND : ST_RUN;
                ST_RUN:  if (w_hs)  state_d = ST_PEND;
                ST_PEND: if (w_div) state_d = ST_RUN;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs decoded from state; div_out is suppressed as soon as enable drops
    always_comb begin
        w_active  = (state_q == ST_RUN) | (state_q == ST_PEND);
        w_div     = enable & w_active & (cnt_q == '0);
        div_out   = w_div;
        cfg_ready = ~pend_q;
    end

    // Counter, modulus, ratio registers and sticky clamp next values
    always_comb begin
        cnt_d      = cnt_q;
        mod_d      = mod_q;
        act_int_d  = act_int_q;
        act_frac_d = act_frac_q;
        shd_int_d  = shd_int_q;
        shd_frac_d = shd_frac_q;
        pend_d     = pend_q;
        clamp_d    = clamp_q;

        if (w_load) begin
            cnt_d   = w_mod - C_ONE;
            mod_d   = w_mod;
            clamp_d = clamp_q | w_clamped;
        end else if (enable && w_active) begin
            cnt_d = cnt_q - C_ONE;
        end

        if (w_apply) begin
            act_int_d  = shd_int_q;
            act_frac_d = shd_frac_q;
            pend_d     = 1'b0;
        end

        if (w_hs) begin
            shd_int_d  = cfg_int;
            shd_frac_d = cfg_frac;
            pend_d     = 1'b1;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= '0;
            mod_q      <= '0;
            act_int_q  <= '0;
            act_frac_q <= '0;
            shd_int_q  <= '0;
            shd_frac_q <= '0;
            pend_q     <= 1'b0;
            clamp_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            mod_q      <= mod_d;
            act_int_q  <= act_int_d;
            act_frac_q <= act_frac_d;
            shd_int_q  <= shd_int_d;
            shd_frac_q <= shd_frac_d;
            pend_q     <= pend_d;
            clamp_q    <= clamp_d;
        end
    end

    assign frac_word  = act_frac_q;
    assign modulus    = mod_q;
    assign clamp_flag = clamp_q;

`ifdef DIV_PULSE_CNT_EN
    localparam logic [PCNT_W-1:0] C_PCNT_ONE = 16'd1;

    logic [PCNT_W-1:0] pcnt_q, pcnt_d;

    // Free-running count of divider pulses, wrapping naturally
    always_comb begin
        pcnt_d = pcnt_q;
        if (w_div) begin
            pcnt_d = pcnt_q + C_PCNT_ONE;
        end
    end

    // Pulse counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

    assign pulse_cnt = pcnt_q;
`endif

endmodule : mash_div_ctrl
`default_nettype wire

// File: tb/tb_mash_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mash_div_ctrl
// Purpose  : Scoreboard bench for mash_div_ctrl. The driver keeps a
//            period-level model (remaining cycles, active/shadow ratio) and
//            pushes the expected period length at each load; the monitor
//            measures the real distance between div_out pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mash_div_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [7:0]  cfg_int = '0;
    logic [15:0] cfg_frac = '0;
    logic [3:0]  ddsm_c = '0;
    logic        cfg_ready;
    logic [15:0] frac_word;
    logic        div_out;
    logic [7:0]  modulus;
    logic        clamp_flag;
`ifdef DIV_PULSE_CNT_EN
    logic [15:0] pulse_cnt;
`endif

    mash_div_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_int    (cfg_int),
        .cfg_frac   (cfg_frac),
        .ddsm_c     (ddsm_c),
        .frac_word  (frac_word),
        .div_out    (div_out),
        .modulus    (modulus),
        .clamp_flag (clamp_flag)
`ifdef DIV_PULSE_CNT_EN
        ,
        .pulse_cnt  (pulse_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    bit m_run = 0, m_pend = 0, m_sticky = 0;
    int m_rem = 0, m_mod = 0, m_act_n = 0, m_act_f = 0;
    int m_shd_n = 0, m_shd_f = 0, m_pulses = 0;
    int c_mode = 0, c_fix = 0, c_tog = 1;
    int exp_q[$];
    bit flush = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: check held outputs, drive inputs, advance the model
    task automatic step(input bit en, input bit hv, input int n, input int f);
        bit load, hs, clamped;
        int c, m;
        @(negedge clk);
        check("cfg_ready", cfg_ready, !m_pend);
        check("frac_word", frac_word, m_act_f);
        check("modulus", modulus, m_mod);
        check("clamp_flag", clamp_flag, m_sticky);
`ifdef DIV_PULSE_CNT_EN
        check("pulse_cnt", pulse_cnt, m_pulses);
`endif
        if (!rst) rst = 1'b1;
        load = en && (!m_run || m_rem == 1);
        if (load) begin
            case (c_mode)
                0:       c = c_fix;
                1:       begin c = c_tog; c_tog = -c_tog; end
                default: c = int'($urandom_range(0, 15)) - 8;
            endcase
        end else begin
            c = int'($urandom_range(0, 15)) - 8;
        end
        ddsm_c    = c[3:0];
        enable    = en;
        cfg_valid = hv;
        cfg_int   = hv ? 8'(n) : 8'($urandom);
        cfg_frac  = hv ? 16'(f) : 16'($urandom);

        hs = hv && !m_pend;
        if (en && m_run && m_rem == 1) m_pulses = (m_pulses + 1) % 65536;
        if (m_pend && (!m_run || (en && m_rem == 1))) begin
            m_act_n = m_shd_n;
            m_act_f = m_shd_f;
            m_pend  = 0;
        end
        if (load) begin
            m = m_act_n + c;
            clamped = 0;
            if (m < 2) begin m = 2; clamped = 1; end
            else if (m > 255) begin m = 255; clamped = 1; end
            exp_q.push_back(m);
            m_mod = m;
            m_rem = m;
            m_run = 1;
            if (clamped) m_sticky = 1;
        end else if (m_run && en) begin
            m_rem--;
        end
        if (!en) begin
            if (m_run) exp_q.delete();
            m_run = 0;
        end
        if (hs) begin
            m_shd_n = n;
            m_shd_f = f;
            m_pend  = 1;
        end
    endtask

    task automatic run(input int cycles, input bit en);
        for (int i = 0; i < cycles; i++) step(en, 0, 0, 0);
    endtask

    // Load a ratio from IDLE: handshake, then the idle-apply cycle
    task automatic load_idle(input int n, input int f);
        step(0, 1, n, f);
        step(0, 0, 0, 0);
    endtask

    // Offer a word in exactly the cycle of a div_out pulse
    task automatic hs_at_div(input int n, input int f);
        int guard = 0;
        while (!(m_run && m_rem == 1) && guard < 400) begin
            step(1, 0, 0, 0);
            guard++;
        end
        check("hs_align_timeout", guard < 400, 1);
        step(1, 1, n, f);
    endtask

    task automatic reset_mid();
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_div_out", div_out, 0);
        check("rst_modulus", modulus, 0);
        check("rst_frac_word", frac_word, 0);
        check("rst_clamp_flag", clamp_flag, 0);
        check("rst_cfg_ready", cfg_ready, 1);
        m_run = 0; m_pend = 0; m_sticky = 0; m_rem = 0; m_mod = 0;
        m_act_n = 0; m_act_f = 0; m_shd_n = 0; m_shd_f = 0; m_pulses = 0;
        exp_q.delete();
        flush = 1;
    endtask

    // Monitor: measures cycles between div_out pulses and scores them
    initial begin : monitor
        int cyc = 0;
        bit armed = 0;
        int exp_m;
        forever begin
            @(posedge clk);
            #1;
            if (flush) begin
                armed = 0;
                cyc   = 0;
                flush = 0;
            end
            if (!rst || !enable) begin
                armed = 0;
                cyc   = 0;
                check("div_out_idle", div_out, 0);
            end else begin
                if (!armed) begin
                    armed = 1;
                    cyc   = 0;
                end
                cyc++;
                if (div_out) begin
                    if (exp_q.size() == 0) begin
                        check("div_out_unexpected", 1, 0);
                    end else begin
                        exp_m = exp_q.pop_front();
                        check("period", cyc, exp_m);
                        check("modulus_at_div", modulus, exp_m);
                    end
                    cyc = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog timeout");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
        $fatal(1, "timeout");
    end

    initial begin : driver
        #1;
        check("rst0_div_out", div_out, 0);
        check("rst0_modulus", modulus, 0);
        check("rst0_cfg_ready", cfg_ready, 1);
        check("rst0_clamp_flag", clamp_flag, 0);
        check("rst0_frac_word", frac_word, 0);

        // N=8, c=0: period 8
        step(0, 0, 0, 0);
        load_idle(8, 0);
        c_mode = 0; c_fix = 0;
        run(26, 1);

        // c toggling +1/-1: periods 9 and 7
        c_mode = 1; c_tog = 1;
        run(40, 1);
        run(3, 0);

        // N=10 running, mid-period handshake to N=12, then a non-ready offer
        load_idle(10, 16'h1234);
        c_mode = 0; c_fix = 0;
        run(15, 1);
        step(1, 1, 12, 16'hABCD);
        step(1, 1, 77, 16'h7777);
        run(40, 1);
        run(2, 0);

        // clamp low then clamp high
        load_idle(2, 16'h0002);
        c_fix = -3;
        run(8, 1);
        run(2, 0);
        load_idle(255, 16'hFFFF);
        c_fix = 4;
        run(520, 1);
        run(2, 0);

        // handshake coincident with div_out
        load_idle(6, 16'h0606);
        c_fix = 0;
        run(10, 1);
        hs_at_div(9, 16'h0909);
        run(30, 1);

        // randomized traffic
        c_mode = 2;
        for (int i = 0; i < 700; i++) begin
            step($urandom_range(0, 49) != 0, $urandom_range(0, 7) == 0,
                 int'($urandom_range(2, 20)), int'($urandom_range(0, 65535)));
        end

        // reset mid-period with a shadow word pending
        c_mode = 0; c_fix = 0;
        run(2, 0);
        load_idle(15, 16'h1515);
        run(5, 1);
        step(1, 1, 40, 16'h4040);
        run(3, 1);
        reset_mid();
        c_fix = 1;
        run(12, 1);

        check("queue_depth", exp_q.size(), m_run ? 1 : 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_mash_div_ctrl
`default_nettype wire
